// File: rtl/dds_cfg_pkg.sv
// Shared types and default widths for the DDS configuration write scheduler.
package dds_cfg_pkg;

    localparam int unsigned AddrWidthDefault = 8;
    localparam int unsigned CfgWidthDefault  = 9;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StSettle,
        StAck
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IdW-1:0]     ptr,
    output logic [IdW-1:0]     winner,
    output logic               any_req
);

    int unsigned    sum;
    logic [IdW-1:0] idx;

    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        sum     = 0;
        idx     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sum = 32'(ptr) + i;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            idx = IdW'(sum);
            if (!any_req && req[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dds_cfg_sched.sv
// Arbitrates requester config writes onto a single DDS config port with post-write settle time.
// Optional DDS_CFG_DEDUP_EN: per-requester shadows turn repeated identical writes into a bare ack.
module dds_cfg_sched
    import dds_cfg_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned ADDR_WIDTH    = AddrWidthDefault,
    parameter int unsigned CFG_WIDTH     = CfgWidthDefault,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [NUM_REQ-1:0]                              req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]                   req_addr,
    input  logic [NUM_REQ*CFG_WIDTH-1:0]                    req_data,
    output logic [NUM_REQ-1:0]                              req_ready,
    output logic                                            dds_wr,
    output logic [ADDR_WIDTH-1:0]                           dds_waddr,
    output logic [CFG_WIDTH-1:0]                            dds_wdata,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
    output logic                                            busy
);

    localparam int unsigned IdW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SettleLast = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam int unsigned CntW       = (SettleLast > 0) ? $clog2(SettleLast + 1) : 1;

    state_e               state_q;
    logic [CntW-1:0]      settle_cnt;
    logic [IdW-1:0]       rr_ptr;
    logic [IdW-1:0]       winner;
    logic [IdW-1:0]       next_ptr;
    logic                 any_req;
    logic                 dup;
    logic [NUM_REQ-1:0]   grant_oh;
    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
    logic [CFG_WIDTH-1:0]  data_arr [NUM_REQ];
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [CFG_WIDTH-1:0]  win_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            data_arr[i] = req_data[i*CFG_WIDTH +: CFG_WIDTH];
            grant_oh[i] = (winner == IdW'(i));
        end
    end

    assign win_addr = addr_arr[winner];
    assign win_data = data_arr[winner];
    assign next_ptr = (grant_id == IdW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

`ifdef DDS_CFG_DEDUP_EN
    logic [ADDR_WIDTH-1:0] sh_addr [NUM_REQ];
    logic [CFG_WIDTH-1:0]  sh_data [NUM_REQ];
    logic [NUM_REQ-1:0]    sh_valid;

    // Shadow captures what actually reached the DDS, so it loads only from WRITE.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_valid <= '0;
        end else if (state_q == StWrite) begin
            sh_valid[grant_id] <= 1'b1;
            sh_addr[grant_id]  <= dds_waddr;
            sh_data[grant_id]  <= dds_wdata;
        end
    end

    assign dup = sh_valid[winner] && (sh_addr[winner] == win_addr) &&
                 (sh_data[winner] == win_data);
`else
    assign dup = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            settle_cnt <= '0;
            rr_ptr     <= '0;
            dds_wr     <= 1'b0;
            dds_waddr  <= '0;
            dds_wdata  <= '0;
            req_ready  <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
        end else begin
            dds_wr    <= 1'b0;
            req_ready <= '0;
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        grant_id  <= winner;
                        req_ready <= grant_oh;
                        busy      <= 1'b1;
                        if (dup) begin
                            state_q <= StAck;
                        end else begin
                            state_q   <= StWrite;
                            dds_wr    <= 1'b1;
                            dds_waddr <= win_addr;
                            dds_wdata <= win_data;
                        end
                    end
                end
                StWrite: begin
                    rr_ptr <= next_ptr;
                    if (SETTLE_CYCLES > 0) begin
                        state_q    <= StSettle;
                        settle_cnt <= CntW'(SettleLast);
                    end else begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                end
                StSettle: begin
                    if (settle_cnt == '0) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                StAck: begin
                    rr_ptr  <= next_ptr;
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dds_cfg_sched.sv
// Scoreboard bench for dds_cfg_sched: a SETTLE_CYCLES=4 instance and a SETTLE_CYCLES=0 instance.
module tb_dds_cfg_sched;

    localparam int AW = 8;
    localparam int CW = 9;

    typedef struct {
        int cyc;
        int id;
        int wr;
        int addr;
        int data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    logic [3:0]    req_valid = '0, req_valid0 = '0;
    logic [4*AW-1:0] req_addr = '0, req_addr0 = '0;
    logic [4*CW-1:0] req_data = '0, req_data0 = '0;
    logic [3:0]    req_ready, req_ready0;
    logic          dds_wr, dds_wr0;
    logic [AW-1:0] dds_waddr, dds_waddr0;
    logic [CW-1:0] dds_wdata, dds_wdata0;
    logic [1:0]    grant_id, grant_id0;
    logic          busy, busy0;

    exp_t q4[$];
    exp_t q0[$];
    exp_t e4, e0;

    dds_cfg_sched #(.NUM_REQ(4), .ADDR_WIDTH(AW), .CFG_WIDTH(CW), .SETTLE_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .dds_wr    (dds_wr),
        .dds_waddr (dds_waddr),
        .dds_wdata (dds_wdata),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    dds_cfg_sched #(.NUM_REQ(4), .ADDR_WIDTH(AW), .CFG_WIDTH(CW), .SETTLE_CYCLES(0)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid0),
        .req_addr  (req_addr0),
        .req_data  (req_data0),
        .req_ready (req_ready0),
        .dds_wr    (dds_wr0),
        .dds_waddr (dds_waddr0),
        .dds_wdata (dds_wdata0),
        .grant_id  (grant_id0),
        .busy      (busy0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push4(int c, int id, int wr, int a, int d);
        exp_t e;
        e = '{cyc: c, id: id, wr: wr, addr: a, data: d};
        q4.push_back(e);
    endfunction

    function automatic void push0(int c, int id, int a, int d);
        exp_t e;
        e = '{cyc: c, id: id, wr: 1, addr: a, data: d};
        q0.push_back(e);
    endfunction

    // Monitors: every strobe must match the head of its queue.
    always @(negedge clk) begin
        if (dds_wr || (req_ready != 4'b0)) begin
            if (q4.size() == 0) begin
                check("dut4_unexpected_strobe", {27'b0, dds_wr, req_ready}, 0);
            end else begin
                e4 = q4.pop_front();
                check("dut4_cycle", cyc, e4.cyc);
                check("dut4_dds_wr", 32'(dds_wr), e4.wr);
                check("dut4_req_ready", 32'(req_ready), 1 << e4.id);
                check("dut4_grant_id", 32'(grant_id), e4.id);
                check("dut4_dds_waddr", 32'(dds_waddr), e4.addr);
                check("dut4_dds_wdata", 32'(dds_wdata), e4.data);
            end
        end
    end

    always @(negedge clk) begin
        if (dds_wr0 || (req_ready0 != 4'b0)) begin
            if (q0.size() == 0) begin
                check("dut0_unexpected_strobe", {27'b0, dds_wr0, req_ready0}, 0);
            end else begin
                e0 = q0.pop_front();
                check("dut0_cycle", cyc, e0.cyc);
                check("dut0_dds_wr", 32'(dds_wr0), e0.wr);
                check("dut0_req_ready", 32'(req_ready0), 1 << e0.id);
                check("dut0_dds_waddr", 32'(dds_waddr0), e0.addr);
                check("dut0_dds_wdata", 32'(dds_wdata0), e0.data);
            end
        end
    end

    // Advance one cycle; acknowledged requesters drop their valid.
    task automatic tick();
        @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (req_ready[i]) req_valid[i] = 1'b0;
            if (req_ready0[i]) req_valid0[i] = 1'b0;
        end
    endtask

    task automatic set_req(input int id, input int a, input int d);
        req_valid[id]          = 1'b1;
        req_addr[id*AW +: AW]  = AW'(a);
        req_data[id*CW +: CW]  = CW'(d);
    endtask

    task automatic set_req0(input int id, input int a, input int d);
        req_valid0[id]         = 1'b1;
        req_addr0[id*AW +: AW] = AW'(a);
        req_data0[id*CW +: CW] = CW'(d);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q4.size() != 0 || busy || q0.size() != 0 || busy0) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle: still busy after %0d cycles, expected idle", n);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_dds_wr"}, 32'(dds_wr), 0);
        check({tag, "_dds_waddr"}, 32'(dds_waddr), 0);
        check({tag, "_dds_wdata"}, 32'(dds_wdata), 0);
        check({tag, "_req_ready"}, 32'(req_ready), 0);
        check({tag, "_grant_id"}, 32'(grant_id), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_rr_ptr"}, 32'(dut.rr_ptr), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;

        // Reset state
        tick();
        tick();
        check_reset_state("reset");
        reset = 1'b0;

        // Single request from requester 1
        c = cyc;
        set_req(1, 'h30, 'h004);
        push4(c + 1, 1, 1, 'h30, 'h004);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("single_busy", 32'(busy), (k <= 5) ? 1 : 0);
        end

        // Fairness: pointer now 2, requesters 0 and 3 contend
        check("fair_rr_ptr", 32'(dut.rr_ptr), 2);
        c = cyc;
        set_req(0, 'h20, 'h0A0);
        set_req(3, 'h23, 'h0A3);
        push4(c + 1, 3, 1, 'h23, 'h0A3);
        push4(c + 7, 0, 1, 'h20, 'h0A0);
        tick();
        wait_idle();

        // Contention from reset: all four valid
        reset = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 'h10 + i, 'h100 + i);
        tick();
        reset = 1'b0;
        c = cyc;
        for (int i = 0; i < 4; i++) push4(c + 1 + 6 * i, i, 1, 'h10 + i, 'h100 + i);
        tick();
        wait_idle();

        // Reset mid-SETTLE with requester 2 pending
        c = cyc;
        set_req(0, 'h44, 'h044);
        push4(c + 1, 0, 1, 'h44, 'h044);
        tick();
        tick();
        set_req(2, 'h52, 'h1A5);
        tick();
        reset = 1'b1;
        tick();
        check_reset_state("midreset");
        reset = 1'b0;
        push4(c + 5, 2, 1, 'h52, 'h1A5);
        tick();
        wait_idle();

        // Dedup: identical write twice; requester 3 withdraws during settle
        c = cyc;
        set_req(0, 'h30, 'h008);
        push4(c + 1, 0, 1, 'h30, 'h008);
        tick();
        tick();
        set_req(3, 'h77, 'h077);
        tick();
        req_valid[3] = 1'b0;
        tick();
        wait_idle();
        c = cyc;
        set_req(0, 'h30, 'h008);
`ifdef DDS_CFG_DEDUP_EN
        push4(c + 1, 0, 0, 'h30, 'h008);
        tick();
        tick();
        check("dedup_busy_after_ack", 32'(busy), 0);
`else
        push4(c + 1, 0, 1, 'h30, 'h008);
        tick();
        tick();
        check("dedup_busy_settle", 32'(busy), 1);
`endif
        wait_idle();

        // SETTLE_CYCLES=0: back-to-back writes every 2 cycles
        reset = 1'b1;
        set_req0(0, 'h60, 'h0A0);
        set_req0(1, 'h61, 'h0A1);
        tick();
        reset = 1'b0;
        c = cyc;
        push0(c + 1, 0, 'h60, 'h0A0);
        push0(c + 3, 1, 'h61, 'h0A1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("settle0_busy", 32'(busy0), k % 2);
        end
        wait_idle();

        check("dut4_queue_drained", q4.size(), 0);
        check("dut0_queue_drained", q0.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dds_cfg_sched.md
DDS_CFG_SCHED -- requirements
Module: dds_cfg_sched

Interface
REQ-001 Parameters SHALL be:
- NUM_REQ, default 4, number of requesters.
- ADDR_WIDTH, default 8, DDS config address width.
- CFG_WIDTH, default 9, DDS config data width.
- SETTLE_CYCLES, default 4, idle cycles after each DDS write (0 legal).
REQ-002 Ports SHALL be:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at slice i.
- req_data  in  NUM_REQ*CFG_WIDTH  packed data; requester i at slice i.
- req_ready  out  NUM_REQ  one-hot, one-cycle acceptance pulse.
- dds_wr  out  1  DDS config write strobe.
- dds_waddr  out  ADDR_WIDTH  DDS config address.
- dds_wdata  out  CFG_WIDTH  DDS config data.
- grant_id  out  clog2(NUM_REQ)  index of the last granted requester.
- busy  out  1  high whenever state is not IDLE.
REQ-003 The block SHALL use one clock, clk; reset SHALL be synchronous and active-high, named reset.

Function
REQ-004 The FSM SHALL have states IDLE, WRITE, SETTLE and ACK.
REQ-005 In IDLE with any req_valid high, the block SHALL select the winner by round-robin, starting the search at pointer rr_ptr.
REQ-006 On that same edge, the block SHALL register the winner's addr/data into dds_waddr/dds_wdata, set grant_id, and go to WRITE.
REQ-007 In WRITE, dds_wr SHALL be 1 and req_ready[grant_id] SHALL be 1 for exactly one cycle; latency from req_valid sampled in IDLE to dds_wr is 1 cycle.
REQ-008 rr_ptr SHALL update to (grant_id+1) mod NUM_REQ on leaving WRITE or ACK.
REQ-009 From WRITE, the next state SHALL be SETTLE if SETTLE_CYCLES>0, else IDLE.
REQ-010 SETTLE SHALL last exactly SETTLE_CYCLES cycles, counted by a down-counter, then return to IDLE; new requests SHALL be ignored until IDLE.
REQ-011 Throughput SHALL be one write per 2+SETTLE_CYCLES cycles.
REQ-012 Requesters SHALL hold req_valid, addr and data stable until req_ready; the block samples them only in IDLE.
REQ-013 A requester deasserting req_valid before its grant SHALL simply lose arbitration, with no side effects.
REQ-014 dds_waddr/dds_wdata SHALL hold their last written values while dds_wr is 0.
REQ-015 With no requests pending, the block SHALL remain in IDLE with all strobes 0.

Reset
REQ-016 When reset is high at a clk edge, regardless of state, the block SHALL enter IDLE and clear the settle counter.
REQ-017 Reset SHALL set dds_wr=0, dds_waddr=0, dds_wdata=0, req_ready=0, grant_id=0, busy=0 and rr_ptr=0.
REQ-018 Reset SHALL clear all dedup shadow-valid bits.
REQ-019 A request interrupted by reset SHALL NOT be acknowledged; it SHALL be re-arbitrated after reset, starting from rr_ptr=0.

Configuration
REQ-020 Macro DDS_CFG_DEDUP_EN SHALL enable per-requester shadow registers (addr, data, valid bit), loaded on every WRITE.
REQ-021 With DDS_CFG_DEDUP_EN defined, a winner whose addr/data equal its valid shadow SHALL go IDLE->ACK instead of WRITE.
REQ-022 ACK SHALL pulse req_ready[grant_id] for one cycle with dds_wr=0, leave dds_waddr/dds_wdata unchanged, skip SETTLE and return to IDLE.
REQ-023 With DDS_CFG_DEDUP_EN undefined, no shadow logic SHALL exist, ACK SHALL be unreachable, and every request SHALL produce a WRITE.

Structure
REQ-024 Package dds_cfg_pkg SHALL hold the state enum type and the default ADDR_WIDTH/CFG_WIDTH constants.
REQ-025 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req vector and ptr; outputs winner index and any_req), combinational.

Verification (NUM_REQ=4, SETTLE_CYCLES=4 unless stated)
REQ-026 Single request: req_valid[1] with addr 0x30, data 0x004 seen in IDLE at cycle 0 -> dds_wr=1, dds_waddr=0x30, dds_wdata=0x004 and req_ready[1]=1 at cycle 1; busy high cycles 1-5; IDLE at cycle 6.
REQ-027 Contention: all four requesters valid from reset -> grants 0,1,2,3, with dds_wr at cycles 1, 7, 13, 19.
REQ-028 Fairness: rr_ptr=2 with requesters 0 and 3 valid -> requester 3 granted first, then requester 0.
REQ-029 Reset mid-SETTLE: reset for one cycle -> next cycle all outputs 0 and rr_ptr=0; the pending requester 2 is re-granted with dds_wr exactly once.
REQ-030 Dedup: requester 0 writes 0x30/0x008 twice. With the macro, the second request gets req_ready one cycle after being sampled and no dds_wr. Without the macro, the second request produces a second dds_wr.
REQ-031 SETTLE_CYCLES=0 with two valid requesters -> dds_wr every 2 cycles, busy high only in WRITE cycles.
